// File: rtl/data_mem_resp.sv
// data_mem_resp: MEM-stage data memory with fixed-latency masked stores and extended loads.
// Define DMEM_MISALIGN_TRAP_EN to suppress misaligned accesses and flag them on err_o.
module data_mem_resp #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] addr_i,
    input  logic        mem_wr_i,
    input  logic [7:0]  wmask_i,
    input  logic [63:0] wdata_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] rdata_o,
    output logic        resp_valid_o,
    output logic        stall_o,
    output logic        err_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW+2:0] addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [7:0]    wmask_q, wmask_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [63:0]   mem_q [DEPTH];

    logic          unused_addr;
    logic [2:0]    off;
    logic [IW-1:0] idx;
    logic [63:0]   word;
    logic [7:0]    mask_sh;
    logic [63:0]   data_sh;
    logic [63:0]   wword;
    logic [63:0]   sh;
    logic [63:0]   lres;
    logic          commit;
    logic          mis_trap;
    logic          we;

    // Address bits above the array wrap the index modulo DEPTH.
    assign unused_addr = ^addr_i[63:IW+3];

    assign off  = addr_q[2:0];
    assign idx  = addr_q[IW+2:3];
    assign word = mem_q[idx];

    assign mask_sh = wmask_q << off;
    assign data_sh = wdata_q << {off, 3'b000};
    assign sh      = word >> {off, 3'b000};

    always_comb begin
        wword = word;
        for (int j = 0; j < 8; j++) begin
            if (mask_sh[j]) wword[8*j +: 8] = data_sh[8*j +: 8];
        end
    end

    always_comb begin
        unique case (f3_q)
            3'b000:  lres = {{56{sh[7]}}, sh[7:0]};
            3'b001:  lres = {{48{sh[15]}}, sh[15:0]};
            3'b010:  lres = {{32{sh[31]}}, sh[31:0]};
            3'b100:  lres = {56'b0, sh[7:0]};
            3'b101:  lres = {48'b0, sh[15:0]};
            3'b110:  lres = {32'b0, sh[31:0]};
            default: lres = sh;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic [3:0] top;
    logic [3:0] lbytes;

    // top = index of highest set mask bit plus one; zero for an empty mask.
    always_comb begin
        top = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (wmask_q[i]) top = 4'(i + 1);
        end
    end

    always_comb begin
        unique case (f3_q[1:0])
            2'b00:   lbytes = 4'd1;
            2'b01:   lbytes = 4'd2;
            2'b10:   lbytes = 4'd4;
            default: lbytes = 4'd8;
        endcase
    end

    assign mis_trap = ((wr_q ? top : lbytes) + {1'b0, off}) > 4'd8;
`else
    assign mis_trap = 1'b0;
`endif

    assign commit = (state_q == S_BUSY) && (cnt_q == '0);
    assign we     = commit && wr_q && !mis_trap && !rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = addr_i[IW+2:0];
                    wr_d    = mem_wr_i;
                    wmask_d = wmask_i;
                    wdata_d = wdata_i;
                    f3_d    = funct3_i;
                    cnt_d   = CNT_INIT;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rdata_d = (wr_q || mis_trap) ? 64'd0 : lres;
                    err_d   = mis_trap;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wmask_q <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[idx] <= wword;
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign stall_o      = (state_q != S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed checks of data_mem_resp stores, loads, reset and pacing.
// Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_data_mem_resp;
    localparam int DEPTH   = 512;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] addr = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  wmask = '0;
    logic [63:0] wdata = '0;
    logic [2:0]  funct3 = '0;
    logic [63:0] rdata;
    logic        resp_valid;
    logic        stall;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_resp #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .addr_i       (addr),
        .mem_wr_i     (mem_wr),
        .wmask_i      (wmask),
        .wdata_i      (wdata),
        .funct3_i     (funct3),
        .rdata_o      (rdata),
        .resp_valid_o (resp_valid),
        .stall_o      (stall),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // lat counts negedges after the accept edge up to the resp_valid sample.
    task automatic access(input logic wr, input logic [63:0] a,
                          input logic [7:0] m, input logic [63:0] d,
                          input logic [2:0] f3, output logic [63:0] rd,
                          output logic er, output int lat, output int stl);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        mem_wr = wr;
        addr = a;
        wmask = m;
        wdata = d;
        funct3 = f3;
        @(posedge clk);
        lat = 0;
        stl = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (stall) stl++;
        end while (!resp_valid && lat < 20);
        rd = rdata;
        er = err;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL rst_stall: got %b want 0", stall);
        end
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_resp: got %b want 0", resp_valid);
        end
        n_cmp++;
        if (rdata !== 64'd0) begin
            n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL rst_err: got %b want 0", err);
        end
        rst = 1'b0;
    endtask

    task automatic test_sd_ld();
        logic [63:0] rd;
        logic er;
        int lat, stl;
        access(1'b1, 64'h10, 8'hFF, 64'h8877665544332211, 3'b011, rd, er, lat, stl);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++; $display("FAIL sd_lat: got %0d want 3", lat);
        end
        n_cmp++;
        if (stl !== 3) begin
            n_bad++; $display("FAIL sd_stall: got %0d want 3", stl);
        end
        n_cmp++;
        if (rd !== 64'd0) begin
            n_bad++; $display("FAIL sd_rdata: got %h want 0", rd);
        end
        access(1'b0, 64'h10, 8'h00, 64'd0, 3'b011, rd, er, lat, stl);
        n_cmp++;
        if (rd !== 64'h8877665544332211) begin
            n_bad++; $display("FAIL ld_rdata: got %h want 8877665544332211", rd);
        end
        n_cmp++;
        if (lat !== 3 || stl !== 3) begin
            n_bad++; $display("FAIL ld_timing: got lat %0d stall %0d want 3 3", lat, stl);
        end
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL ld_idle: got stall %b ready %b want 0 1", stall, req_ready);
        end
    endtask

    task automatic test_sh_loads();
        logic [63:0] rd;
        logic er;
        int lat, stl;
        access(1'b1, 64'h16, 8'h03, 64'hFFFF_F00D, 3'b001, rd, er, lat, stl);
        access(1'b0, 64'h16, 8'h00, 64'd0, 3'b001, rd, er, lat, stl);
        n_cmp++;
        if (rd !== 64'hFFFF_FFFF_FFFF_F00D) begin
            n_bad++; $display("FAIL lh: got %h want fffffffffffff00d", rd);
        end
        access(1'b0, 64'h16, 8'h00, 64'd0, 3'b101, rd, er, lat, stl);
        n_cmp++;
        if (rd !== 64'h0000_0000_0000_F00D) begin
            n_bad++; $display("FAIL lhu: got %h want 000000000000f00d", rd);
        end
        access(1'b0, 64'h10, 8'h00, 64'd0, 3'b011, rd, er, lat, stl);
        n_cmp++;
        if (rd !== 64'hF00D_6655_4433_2211) begin
            n_bad++; $display("FAIL sh_word: got %h want f00d665544332211", rd);
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] rd;
        logic er;
        int lat, stl;
        access(1'b1, 64'h18, 8'hFF, 64'hA1B2C3D4E5F60718, 3'b011, rd, er, lat, stl);
        access(1'b0, 64'h1E, 8'h00, 64'd0, 3'b010, rd, er, lat, stl);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_cmp++;
        if (rd !== 64'd0 || er !== 1'b1) begin
            n_bad++; $display("FAIL mis_lw: got %h err %b want 0 err 1", rd, er);
        end
`else
        n_cmp++;
        if (rd !== 64'h0000_0000_0000_A1B2 || er !== 1'b0) begin
            n_bad++; $display("FAIL mis_lw: got %h err %b want a1b2 err 0", rd, er);
        end
`endif
        access(1'b0, 64'h1F, 8'h00, 64'd0, 3'b000, rd, er, lat, stl);
        n_cmp++;
        if (rd !== 64'hFFFF_FFFF_FFFF_FFA1 || er !== 1'b0) begin
            n_bad++; $display("FAIL lb_top: got %h err %b want ffffffffffffffa1 err 0", rd, er);
        end
        access(1'b1, 64'h1C, 8'hFF, 64'h1122334455667788, 3'b011, rd, er, lat, stl);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_cmp++;
        if (er !== 1'b1) begin
            n_bad++; $display("FAIL mis_sd_err: got %b want 1", er);
        end
        access(1'b0, 64'h18, 8'h00, 64'd0, 3'b011, rd, er, lat, stl);
        n_cmp++;
        if (rd !== 64'hA1B2C3D4E5F60718) begin
            n_bad++; $display("FAIL mis_sd_word: got %h want a1b2c3d4e5f60718", rd);
        end
`else
        n_cmp++;
        if (er !== 1'b0) begin
            n_bad++; $display("FAIL mis_sd_err: got %b want 0", er);
        end
        access(1'b0, 64'h18, 8'h00, 64'd0, 3'b011, rd, er, lat, stl);
        n_cmp++;
        if (rd !== 64'h55667788E5F60718) begin
            n_bad++; $display("FAIL mis_sd_word: got %h want 55667788e5f60718", rd);
        end
`endif
        access(1'b1, 64'h18, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, rd, er, lat, stl);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++; $display("FAIL nomask_lat: got %0d want 3", lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd;
        logic er;
        int lat, stl, seen;
        access(1'b1, 64'h20, 8'hFF, 64'h0123456789ABCDEF, 3'b011, rd, er, lat, stl);
        @(negedge clk);
        req_valid = 1'b1;
        mem_wr = 1'b1;
        addr = 64'h20;
        wmask = 8'hFF;
        wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL mid_busy: got stall %b want 1", stall);
        end
        rst = 1'b1;
        #2;
        n_cmp++;
        if (stall !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_rst: got stall %b ready %b want 0 1", stall, req_ready);
        end
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL mid_resp: got %0d pulses want 0", seen);
        end
        access(1'b0, 64'h20, 8'h00, 64'd0, 3'b011, rd, er, lat, stl);
        n_cmp++;
        if (rd !== 64'h0123456789ABCDEF) begin
            n_bad++; $display("FAIL mid_word: got %h want 0123456789abcdef", rd);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] rd;
        logic er;
        int lat, stl;
        access(1'b1, 64'h8, 8'hFF, 64'hCAFEBABE12345678, 3'b011, rd, er, lat, stl);
        access(1'b0, 64'(DEPTH * 8 + 8), 8'h00, 64'd0, 3'b011, rd, er, lat, stl);
        n_cmp++;
        if (rd !== 64'hCAFEBABE12345678) begin
            n_bad++; $display("FAIL wrap_ld: got %h want cafebabe12345678", rd);
        end
        access(1'b0, 64'(DEPTH * 8 + 12), 8'h00, 64'd0, 3'b010, rd, er, lat, stl);
        n_cmp++;
        if (rd !== 64'hFFFF_FFFF_CAFE_BABE) begin
            n_bad++; $display("FAIL wrap_lw: got %h want ffffffffcafebabe", rd);
        end
        access(1'b0, 64'(DEPTH * 8 + 12), 8'h00, 64'd0, 3'b110, rd, er, lat, stl);
        n_cmp++;
        if (rd !== 64'h0000_0000_CAFE_BABE) begin
            n_bad++; $display("FAIL wrap_lwu: got %h want 00000000cafebabe", rd);
        end
    endtask

    // Accept edges are LATENCY+2 apart: LATENCY+1 stalled cycles, then one idle cycle.
    task automatic test_back_to_back();
        int rdy_at[$];
        int resps;
        @(negedge clk);
        req_valid = 1'b1;
        mem_wr = 1'b0;
        addr = 64'h8;
        wmask = 8'h00;
        funct3 = 3'b011;
        resps = 0;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready) rdy_at.push_back(i);
            if (resp_valid) resps++;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (rdy_at.size() !== 3) begin
            n_bad++; $display("FAIL b2b_count: got %0d accepts want 3", rdy_at.size());
        end else begin
            n_cmp++;
            if (rdy_at[1] - rdy_at[0] !== LATENCY + 2 || rdy_at[2] - rdy_at[1] !== LATENCY + 2) begin
                n_bad++; $display("FAIL b2b_gap: got %0d %0d want 4 4",
                                  rdy_at[1] - rdy_at[0], rdy_at[2] - rdy_at[1]);
            end
        end
        n_cmp++;
        if (resps !== 2) begin
            n_bad++; $display("FAIL b2b_resp: got %0d want 2", resps);
        end
        n_cmp++;
        if (rdata !== 64'hCAFEBABE12345678) begin
            n_bad++; $display("FAIL b2b_rdata: got %h want cafebabe12345678", rdata);
        end
    endtask

    initial begin
        test_reset();
        test_sd_ld();
        test_sh_loads();
        test_misaligned();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
